// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory access unit.
//   SIZE_*        : request size field encodings
//   state_e       : access FSM states
//   misalign_err  : alignment / illegal-size check on the request
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Flags a request whose size is illegal or whose address is not
  // naturally aligned for its size. The range check lives in the top
  // because it depends on the RAM depth parameter.
  function automatic logic misalign_err(input logic [1:0] size,
                                        input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return |addr_lo;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Byte-lane steering for the data-memory access unit (combinational).
//   word_i    : word read from RAM
//   wdata_i   : right-justified store data
//   addr_lo_i : byte offset within the word
//   size_i    : access size
//   signed_i  : sign-extend sub-word loads
//   load_o    : extracted + extended load result
//   merge_o   : word_i with the store lane(s) replaced by wdata_i
module mau_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  logic [NUM_LANES-1:0][VEC_W-1:0] old_w, rep_w, mrg_w;
  logic [NUM_LANES-1:0]            be;
  logic [7:0]                      byte_sel;
  logic [15:0]                     half_sel;

  assign old_w = word_i;

  // Replicate the store data across the word so every lane sees its own
  // copy; the byte enables then pick which lanes take it.
  always_comb begin
    be    = 4'b1111;
    rep_w = wdata_i;
    case (size_i)
      SIZE_BYTE: begin
        be    = 4'b0001 << addr_lo_i;
        rep_w = {4{wdata_i[7:0]}};
      end
      SIZE_HALF: begin
        be    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        rep_w = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign mrg_w[l] = be[l] ? rep_w[l] : old_w[l];
  end

  assign merge_o = mrg_w;

  assign byte_sel = old_w[addr_lo_i];
  assign half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    load_o = word_i;
    case (size_i)
      SIZE_BYTE: load_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the data-memory port. Converts byte/half/word loads
// and stores from the MEM stage into word-aligned RAM accesses; sub-word
// stores are done as read-modify-write.
//   clk, reset              : clock, async active-low reset
//   req_valid/req_ready     : request handshake (ready only in IDLE)
//   req_wr/size/signed/addr/wdata : request fields, latched on accept
//   resp_valid/rdata/err    : one-cycle completion pulse with result/error
//   mem_rd/wr/addr/wdata    : word RAM interface (write commits on negedge)
//   mem_rdata               : combinational RAM read data
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int RAM_SIZE_BIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;
  logic [31:0] wdata_q, wdata_d;   // store data, then the merged write word
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] load_w, merge_w;
  logic        req_err;

  mau_lane_align u_align (
    .word_i    (mem_rdata),
    .wdata_i   (wdata_q),
    .addr_lo_i (addr_q[1:0]),
    .size_i    (size_q),
    .signed_i  (signed_q),
    .load_o    (load_w),
    .merge_o   (merge_w)
  );

  assign req_err = misalign_err(req_size, req_addr[1:0]) |
                   (|req_addr[31:RAM_SIZE_BIT+2]);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    signed_d = signed_q;
    wr_d     = wr_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          size_d   = req_size;
          signed_d = req_signed;
          wr_d     = req_wr;
          wdata_d  = req_wdata;
          err_d    = req_err;
          rdata_d  = '0;
          if (req_err)
            state_d = ST_RESP;
          else if (req_wr && req_size == SIZE_WORD)
            state_d = ST_WRITE;
          else
            state_d = ST_READ;
        end
      end
      ST_READ: begin
        // Sub-word stores reuse the store-data register for the merged word.
        if (wr_q) begin
          wdata_d = merge_w;
          state_d = ST_WRITE;
        end else begin
          rdata_d = load_w;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // rdata_q is cleared on accept, so stores and errors return zero.
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = (state_q == ST_RESP) & err_q;
  assign resp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
  assign mem_rd     = (state_q == ST_READ);
  assign mem_wr     = (state_q == ST_WRITE);
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = (state_q == ST_WRITE) ? wdata_q : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wr, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] ram [256];

  always #5 clk = ~clk;

  mem_access_unit #(.RAM_SIZE_BIT(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Word RAM: combinational read, write on negedge.
  assign mem_rdata = mem_rd ? ram[mem_addr[9:2]] : 32'h0;
  always @(negedge clk) if (mem_wr) ram[mem_addr[9:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it to its response (or a cycle budget).
  task automatic do_req(input string tag, input logic wr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata,
                        input int exp_rd, input int exp_wr);
    int lat, nrd, nwr;
    logic [31:0] rdata, waddr;
    logic err;
    for (int i = 0; i < 8 && !req_ready; i++) begin @(posedge clk); #1; end
    req_valid = 1'b1; req_wr = wr; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; rdata = '0; err = 1'b0; waddr = '0;
    for (int c = 1; c <= 8; c++) begin
      if (mem_rd) nrd++;
      if (mem_wr) begin nwr++; waddr = mem_addr; end
      if (resp_valid) begin lat = c; rdata = resp_rdata; err = resp_err; break; end
      @(posedge clk); #1;
    end
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".err"}, {31'b0, err}, {31'b0, exp_err});
    chk({tag, ".rdata"}, rdata, exp_rdata);
    chk({tag, ".rd_cycles"}, nrd, exp_rd);
    chk({tag, ".wr_cycles"}, nwr, exp_wr);
    if (exp_wr > 0) chk({tag, ".waddr"}, waddr, {addr[31:2], 2'b00});
  endtask

  initial begin
    logic [31:0] rsp [3];
    int n_acc, n_rsp, last_c;
    logic rdy;

    reset = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    #12;
    chk("rst.mem_rd", {31'b0, mem_rd}, 32'h0);
    chk("rst.mem_wr", {31'b0, mem_wr}, 32'h0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rst.req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst.resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst.resp_err", {31'b0, resp_err}, 32'h0);
    chk("rst.resp_rdata", resp_rdata, 32'h0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_wdata", mem_wdata, 32'h0);

    // Word store then load
    do_req("sw10", 1, SIZE_WORD, 0, 32'h10, 32'hDEADBEEF, 2, 0, 32'h0, 0, 1);
    chk("sw10.ram", ram[4], 32'hDEADBEEF);
    do_req("lw10", 0, SIZE_WORD, 0, 32'h10, 32'h0, 2, 0, 32'hDEADBEEF, 1, 0);

    // Byte read-modify-write
    do_req("sw20", 1, SIZE_WORD, 0, 32'h20, 32'h11223344, 2, 0, 32'h0, 0, 1);
    do_req("sb22", 1, SIZE_BYTE, 0, 32'h22, 32'h000000AA, 3, 0, 32'h0, 1, 1);
    chk("sb22.ram", ram[8], 32'h11AA3344);

    // Signed / unsigned sub-word loads
    do_req("sw30", 1, SIZE_WORD, 0, 32'h30, 32'h80FF7F01, 2, 0, 32'h0, 0, 1);
    do_req("lb31", 0, SIZE_BYTE, 1, 32'h31, 32'h0, 2, 0, 32'h0000007F, 1, 0);
    do_req("lbu32", 0, SIZE_BYTE, 0, 32'h32, 32'h0, 2, 0, 32'h000000FF, 1, 0);
    do_req("lh32", 0, SIZE_HALF, 1, 32'h32, 32'h0, 2, 0, 32'hFFFF80FF, 1, 0);
    do_req("lb33", 0, SIZE_BYTE, 1, 32'h33, 32'h0, 2, 0, 32'hFFFFFF80, 1, 0);
    do_req("lhu30", 0, SIZE_HALF, 0, 32'h30, 32'h0, 2, 0, 32'h00007F01, 1, 0);
    do_req("sh32", 1, SIZE_HALF, 0, 32'h32, 32'h1234BEEF, 3, 0, 32'h0, 1, 1);
    chk("sh32.ram", ram[12], 32'hBEEF7F01);

    // Errors
    do_req("lh3", 0, SIZE_HALF, 1, 32'h3, 32'h0, 1, 1, 32'h0, 0, 0);
    do_req("sw400", 1, SIZE_WORD, 0, 32'h400, 32'h12345678, 1, 1, 32'h0, 0, 0);
    do_req("size11", 0, 2'b11, 0, 32'h10, 32'h0, 1, 1, 32'h0, 0, 0);
    do_req("sw12", 1, SIZE_WORD, 0, 32'h12, 32'hFFFFFFFF, 1, 1, 32'h0, 0, 0);
    chk("sw400.ram10", ram[4], 32'hDEADBEEF);

    // Back-to-back loads with req_valid held high
    do_req("sw40", 1, SIZE_WORD, 0, 32'h40, 32'hA0A0A001, 2, 0, 32'h0, 0, 1);
    do_req("sw44", 1, SIZE_WORD, 0, 32'h44, 32'hB0B0B002, 2, 0, 32'h0, 0, 1);
    do_req("sw48", 1, SIZE_WORD, 0, 32'h48, 32'hC0C0C003, 2, 0, 32'h0, 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = 1'b0; req_size = SIZE_WORD; req_signed = 1'b0;
    req_addr = 32'h40;
    n_acc = 0; n_rsp = 0; last_c = 0;
    for (int c = 1; c <= 20; c++) begin
      rdy = req_ready & req_valid;
      @(posedge clk); #1;
      if (rdy) begin
        n_acc++;
        if (n_acc == 3) req_valid = 1'b0;
        else req_addr = req_addr + 32'h4;
      end
      if (resp_valid) begin
        if (n_rsp < 3) rsp[n_rsp] = resp_rdata;
        n_rsp++;
        last_c = c;
      end
      if (n_rsp == 3) break;
    end
    req_valid = 1'b0;
    chk("b2b.accepts", n_acc, 3);
    chk("b2b.resps", n_rsp, 3);
    chk("b2b.last_cycle", last_c, 8);
    chk("b2b.rsp0", rsp[0], 32'hA0A0A001);
    chk("b2b.rsp1", rsp[1], 32'hB0B0B002);
    chk("b2b.rsp2", rsp[2], 32'hC0C0C003);

    // Reset during the WRITE of a sub-word store
    repeat (2) begin @(posedge clk); #1; end
    req_valid = 1'b1; req_wr = 1'b1; req_size = SIZE_BYTE; req_signed = 1'b0;
    req_addr = 32'h24; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort.read", {31'b0, mem_rd}, 32'h1);
    @(posedge clk); #1;
    chk("abort.write", {31'b0, mem_wr}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("abort.mem_wr_drop", {31'b0, mem_wr}, 32'h0);
    chk("abort.mem_rd", {31'b0, mem_rd}, 32'h0);
    chk("abort.no_resp", {31'b0, resp_valid}, 32'h0);
    repeat (2) begin @(posedge clk); #1; end
    chk("abort.no_resp2", {31'b0, resp_valid}, 32'h0);
    @(negedge clk); reset = 1'b1;
    #1;
    chk("abort.ready", {31'b0, req_ready}, 32'h1);
    @(posedge clk); #1;
    chk("abort.no_resp3", {31'b0, resp_valid}, 32'h0);
    do_req("lw10b", 0, SIZE_WORD, 0, 32'h10, 32'h0, 2, 0, 32'hDEADBEEF, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
